ps2_host_tx: RTL and testbench

//  PS/2 host-to-device transmitter; the send side of our keyboard receive path.

---
 rtl/ps2_host_tx_pkg.sv | 24 ++
 rtl/ps2_sync_edge.sv | 33 +++
 rtl/ps2_host_tx.sv | 161 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command/response bytes, frame builder.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_ACK       = 3'd3,
    ST_WAIT_IDLE = 3'd4,
    ST_DONE      = 3'd5,
    ST_ERR       = 3'd6
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;

  // Bits shifted out after the start bit: data LSB-first, odd parity, stop.
  function automatic logic [9:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for the PS/2 clock and data pins plus a clock falling-edge pulse.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic [1:0] meta_q;
  logic [1:0] sync_q;
  logic       clk_prev_q;

  // Lines idle high, so reset to 1 to avoid a spurious fall after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q     <= 2'b11;
      sync_q     <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      meta_q     <= {clk_in, data_in};
      sync_q     <= meta_q;
      clk_prev_q <= sync_q[1];
    end
  end

  assign clk_sync  = sync_q[1];
  assign data_sync = sync_q[0];
  assign clk_fall  = clk_prev_q & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-collector pull-low enables.
// Optional frame timeout enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int INHIBIT_US  = 100,
  parameter int TIMEOUT_CYC = 1_500_000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_drive_low,
  output logic       ps2data_drive_low
);

  localparam int INHIBIT_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
  localparam int INH_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
  localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYC - 2);

  logic clk_sync, data_sync, clk_fall;

  ps2_sync_edge u_sync (
    .clk       (CLK),
    .rst_n     (RST_N),
    .clk_in    (ps2clk_in),
    .data_in   (ps2data_in),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .clk_fall  (clk_fall)
  );

  ps2_tx_state_e    state_q, state_d;
  logic [9:0]       frame_q, frame_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic             data_low_q, data_low_d;
  logic             clk_low_q, clk_low_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    bit_cnt_d  = bit_cnt_q;
    inh_cnt_d  = inh_cnt_q;
    data_low_d = data_low_q;
`ifdef PS2_TX_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tx_valid && ready_q) begin
          frame_d    = ps2_frame(tx_data);
          bit_cnt_d  = 4'd0;
          inh_cnt_d  = '0;
          data_low_d = (INHIBIT_CYC == 1);
          state_d    = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        inh_cnt_d = inh_cnt_q + 1'b1;
        // Start bit goes out on the final inhibit cycle.
        if (inh_cnt_q == INH_PRE) data_low_d = 1'b1;
        if (inh_cnt_q == INH_LAST) begin
          state_d = ST_RELEASE;
`ifdef PS2_TX_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      ST_RELEASE: begin
        if (clk_fall) begin
          data_low_d = ~frame_q[bit_cnt_q];
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (clk_fall) state_d = data_sync ? ST_ERR : ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (clk_sync && data_sync) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // One budget for the whole device-clocked part of the frame.
    if (state_q == ST_RELEASE || state_q == ST_ACK || state_q == ST_WAIT_IDLE) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
      if (tmo_cnt_q == TMO_LAST) state_d = ST_ERR;
    end
`endif

    if (state_d == ST_IDLE || state_d == ST_DONE || state_d == ST_ERR) data_low_d = 1'b0;
    clk_low_d = (state_d == ST_INHIBIT);
    ready_d   = (state_d == ST_IDLE);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    err_d     = (state_d == ST_ERR);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      inh_cnt_q  <= '0;
      data_low_q <= 1'b0;
      clk_low_q  <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      bit_cnt_q  <= bit_cnt_d;
      inh_cnt_q  <= inh_cnt_d;
      data_low_q <= data_low_d;
      clk_low_q  <= clk_low_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef PS2_TX_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
`endif
    end
  end

  assign tx_ready          = ready_q;
  assign busy              = busy_q;
  assign tx_done           = done_q;
  assign tx_err            = err_q;
  assign ps2clk_drive_low  = clk_low_q;
  assign ps2data_drive_low = data_low_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out, compared against a wire-level frame model.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int CLK_HZ      = 4_000_000;
  localparam int INHIBIT_US  = 5;
  localparam int TIMEOUT_CYC = 3000;
  localparam int INH_CYC     = CLK_HZ / 1_000_000 * INHIBIT_US;
  localparam int H           = 10;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_err;
  logic       ps2clk_in, ps2data_in, ps2clk_drive_low, ps2data_drive_low;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  assign ps2clk_in  = ~(ps2clk_drive_low | dev_clk_low);
  assign ps2data_in = ~(ps2data_drive_low | dev_data_low);

  ps2_host_tx #(.CLK_HZ(CLK_HZ), .INHIBIT_US(INHIBIT_US), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .CLK               (CLK),
    .RST_N             (RST_N),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .busy              (busy),
    .tx_done           (tx_done),
    .tx_err            (tx_err),
    .ps2clk_in         (ps2clk_in),
    .ps2data_in        (ps2data_in),
    .ps2clk_drive_low  (ps2clk_drive_low),
    .ps2data_drive_low (ps2data_drive_low)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  always @(negedge CLK) begin
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
  end

  typedef struct {
    logic [7:0] data;
    bit         ack_low;
    bit         poke;
    bit         exp_done;
    bit         exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wire order: [0] start, [8:1] data LSB-first, [9] parity, [10] stop.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = ($countones(d) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic start_frame(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 200) begin tick(); n++; end
    check("ready_before_accept", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("ready_low_after_accept", tx_ready, 0);
  endtask

  task automatic measure_inhibit;
    int n = 0;
    int dl = 0;
    logic last = 1'b0;
    while (ps2clk_drive_low && n < INH_CYC + 100) begin
      n++;
      if (ps2data_drive_low) dl++;
      last = ps2data_drive_low;
      tick();
    end
    check("inhibit_len", n, INH_CYC);
    check("start_low_cycles_in_inhibit", dl, 1);
    check("start_low_on_last_inhibit", last, 1);
  endtask

  task automatic dev_bit(output logic s);
    repeat (H) tick();
    dev_clk_low = 1'b1;
    repeat (H) tick();
    dev_clk_low = 1'b0;
    #1 s = ps2data_in;
  endtask

  task automatic run_frame(input logic [7:0] d, input bit ack_low, input bit poke,
                           input bit exp_done, input bit exp_err);
    int d0, e0, n;
    logic [10:0] got;
    logic s;
    d0 = done_cnt;
    e0 = err_cnt;
    start_frame(d);
    if (poke) begin tx_data = 8'h55; tx_valid = 1'b1; end
    measure_inhibit();
    got[0] = ps2data_in;
    for (int i = 1; i <= 10; i++) begin dev_bit(s); got[i] = s; end
    repeat (H) tick();
    dev_data_low = ack_low;
    repeat (H) tick();
    dev_clk_low = 1'b1;
    repeat (H) tick();
    dev_clk_low = 1'b0;
    repeat (H) tick();
    tx_valid = 1'b0;
    dev_data_low = 1'b0;
    n = 0;
    while (!tx_ready && n < 100) begin tick(); n++; end
    repeat (3) tick();
    check("frame_bits", got, model_frame(d));
    check("done_pulses", done_cnt - d0, exp_done ? 1 : 0);
    check("err_pulses", err_cnt - e0, exp_err ? 1 : 0);
    check("ready_after_frame", tx_ready, 1);
    check("busy_after_frame", busy, 0);
    check("clk_released", ps2clk_drive_low, 0);
    check("data_released", ps2data_drive_low, 0);
    $display("frame data=%02h ack_low=%0d poke=%0d bits=%03h done=%0d err=%0d",
             d, ack_low, poke, got, done_cnt - d0, err_cnt - e0);
  endtask

  initial begin
    vecs[0] = '{PS2_CMD_SET_LEDS, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{PS2_CMD_RESET,    1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h00,            1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h80,            1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{PS2_CMD_SET_LEDS, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h7E,            1'b0, 1'b0, 1'b0, 1'b1};

    repeat (3) tick();
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_err", tx_err, 0);
    check("rst_clk_low", ps2clk_drive_low, 0);
    check("rst_data_low", ps2data_drive_low, 0);
    RST_N = 1'b1;
    repeat (3) tick();

    for (int v = 0; v < 6; v++)
      run_frame(vecs[v].data, vecs[v].ack_low, vecs[v].poke, vecs[v].exp_done, vecs[v].exp_err);

    for (int k = 0; k < 6; k++) begin
      logic [7:0] rd;
      bit ack;
      rd  = 8'($urandom_range(0, 255));
      ack = ($urandom_range(0, 1) == 1);
      run_frame(rd, ack, 1'b0, ack, !ack);
    end

    // Reset after bit 4 of 8'hA5 has been put on the wire.
    begin
      int d0, e0;
      logic s;
      start_frame(8'hA5);
      measure_inhibit();
      for (int i = 0; i < 5; i++) dev_bit(s);
      repeat (4) tick();
      d0 = done_cnt;
      e0 = err_cnt;
      RST_N = 1'b0;
      #1;
      check("midrst_clk_low", ps2clk_drive_low, 0);
      check("midrst_data_low", ps2data_drive_low, 0);
      check("midrst_ready", tx_ready, 1);
      check("midrst_busy", busy, 0);
      repeat (3) tick();
      RST_N = 1'b1;
      repeat (3) tick();
      check("midrst_no_done", done_cnt - d0, 0);
      check("midrst_no_err", err_cnt - e0, 0);
      $display("reset mid-frame data=a5 after bit 4");
      run_frame(8'hF4, 1'b1, 1'b0, 1'b1, 1'b0);
    end

`ifdef PS2_TX_TIMEOUT_EN
    begin
      int n = 0;
      start_frame(8'h3C);
      measure_inhibit();
      while (!tx_err && n < TIMEOUT_CYC + 50) begin tick(); n++; end
      check("timeout_cycles", n, TIMEOUT_CYC);
      check("timeout_clk_released", ps2clk_drive_low, 0);
      check("timeout_data_released", ps2data_drive_low, 0);
      repeat (3) tick();
      check("timeout_ready", tx_ready, 1);
      $display("timeout frame data=3c cycles=%0d", n);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
